// File: rtl/snoop_bus_if.sv
// snoop_bus_if: core request, snoop broadcast, snoop response and completion signals of the snoop bus
interface snoop_bus_if #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int TYPE_WIDTH = 2
);
    localparam int ID_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    logic [NUM_CORES-1:0]                 core_req_valid;
    logic [NUM_CORES-1:0]                 core_req_ready;
    logic [NUM_CORES-1:0][TYPE_WIDTH-1:0] core_req_type;
    logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_req_addr;
    logic                                 bus_valid;
    logic [ADDR_WIDTH-1:0]                bus_addr;
    logic [TYPE_WIDTH-1:0]                bus_type;
    logic [ID_W-1:0]                      bus_src_id;
    logic [NUM_CORES-1:0]                 snoop_valid;
    logic [NUM_CORES-1:0]                 snoop_shared;
    logic [NUM_CORES-1:0]                 snoop_dirty;
    logic                                 done_valid;
    logic [ID_W-1:0]                      done_core_id;
    logic                                 done_shared;
    logic                                 done_dirty;
    logic                                 done_timeout;
    modport master (
        input  core_req_valid, core_req_type, core_req_addr, snoop_valid, snoop_shared, snoop_dirty,
        output core_req_ready, bus_valid, bus_addr, bus_type, bus_src_id,
               done_valid, done_core_id, done_shared, done_dirty, done_timeout
    );
    modport slave (
        output core_req_valid, core_req_type, core_req_addr, snoop_valid, snoop_shared, snoop_dirty,
        input  core_req_ready, bus_valid, bus_addr, bus_type, bus_src_id,
               done_valid, done_core_id, done_shared, done_dirty, done_timeout
    );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin request arbiter, one-cycle snoop broadcast and bounded snoop response collector
module snoop_bus_ctrl #(
    parameter int NUM_CORES     = 4,
    parameter int ADDR_WIDTH    = 64,
    parameter int TYPE_WIDTH    = 2,
    parameter int SNOOP_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    snoop_bus_if.master b
);
    localparam int ID_W  = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = SNOOP_TIMEOUT > 1 ? $clog2(SNOOP_TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, BROADCAST, COLLECT, DONE} state_e;
    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, bus_src_q, bus_src_d, grant_id, idx;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [TYPE_WIDTH-1:0] bus_type_q, bus_type_d;
    logic [NUM_CORES-1:0]  exp_q, exp_d, got_q, got_d, got_n, shared_q, shared_d, dirty_q, dirty_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tmo_q, tmo_d, grant_found;
    always_comb begin
        grant_found = 1'b0;
        grant_id = '0;
        idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % NUM_CORES);
            if (!grant_found && b.core_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id = idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            bus_src_q <= '0;
            bus_addr_q <= '0;
            bus_type_q <= '0;
            exp_q <= '0;
            got_q <= '0;
            shared_q <= '0;
            dirty_q <= '0;
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            bus_src_q <= bus_src_d;
            bus_addr_q <= bus_addr_d;
            bus_type_q <= bus_type_d;
            exp_q <= exp_d;
            got_q <= got_d;
            shared_q <= shared_d;
            dirty_q <= dirty_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        bus_src_d = bus_src_q;
        bus_addr_d = bus_addr_q;
        bus_type_d = bus_type_q;
        exp_d = exp_q;
        got_d = got_q;
        shared_d = shared_q;
        dirty_d = dirty_q;
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        got_n = got_q | (b.snoop_valid & exp_q);
        unique case (state_q)
            IDLE: if (grant_found) begin
                state_d = BROADCAST;
                bus_src_d = grant_id;
                bus_addr_d = b.core_req_addr[grant_id];
                bus_type_d = b.core_req_type[grant_id];
            end
            BROADCAST: begin
                state_d = COLLECT;
                exp_d = ~(NUM_CORES'(1) << bus_src_q);
                got_d = '0;
                shared_d = '0;
                dirty_d = '0;
                cnt_d = '0;
                tmo_d = 1'b0;
            end
            COLLECT: begin
                got_d = got_n;
                shared_d = shared_q | (b.snoop_valid & b.snoop_shared & exp_q);
                dirty_d = dirty_q | (b.snoop_valid & b.snoop_dirty & exp_q);
                if (got_n == exp_q) begin
                    state_d = DONE;
                    tmo_d = 1'b0;
                end else if (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                    state_d = DONE;
                    tmo_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                rr_ptr_d = (bus_src_q == ID_W'(NUM_CORES - 1)) ? '0 : bus_src_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        b.core_req_ready = (state_q == IDLE && grant_found && !rst) ? NUM_CORES'(1) << grant_id : '0;
        b.bus_valid = state_q == BROADCAST;
        b.bus_addr = bus_addr_q;
        b.bus_type = bus_type_q;
        b.bus_src_id = bus_src_q;
        b.done_valid = state_q == DONE;
        b.done_core_id = state_q == DONE ? bus_src_q : '0;
        b.done_shared = state_q == DONE && |shared_q;
        b.done_dirty = state_q == DONE && |dirty_q;
        b.done_timeout = state_q == DONE && tmo_q;
    end
    a_ready_onehot: assert property (@(posedge clk) $onehot0(b.core_req_ready));
    a_bus_state: assert property (@(posedge clk) b.bus_valid |-> state_q == BROADCAST);
    a_done_gap: assert property (@(posedge clk) disable iff (rst) b.done_valid |=> !b.done_valid);
endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
Parametrised next-generation snoop coherency bus for the N-core MOESI system. It arbitrates core requests round-robin with a valid/ready handshake and registers the winner. It broadcasts the granted request for one cycle, then collects per-core snoop responses (shared/dirty) from every non-requesting core, with a bounded timeout. It reports an aggregated completion pulse back to the cache controllers.

Parameters:
NUM_CORES, 4, number of cores/ports (1..16)
ADDR_WIDTH, 64, request address width
TYPE_WIDTH, 2, request type width (encoding opaque to this block)
SNOOP_TIMEOUT, 16, max COLLECT cycles before forced completion (>=1)
ID_W (localparam), max(1,$clog2(NUM_CORES)), core id width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
core_req_valid  in  [NUM_CORES]  per-core request valid
core_req_ready  out  [NUM_CORES]  per-core accept, one-hot or zero
core_req_type  in  [NUM_CORES][TYPE_WIDTH]  request type
core_req_addr  in  [NUM_CORES][ADDR_WIDTH]  request address
bus_valid  out  1  broadcast strobe
bus_addr  out  ADDR_WIDTH  broadcast address (registered)
bus_type  out  TYPE_WIDTH  broadcast type (registered)
bus_src_id  out  ID_W  requesting core id (registered)
snoop_valid  in  [NUM_CORES]  per-core snoop response strobe
snoop_shared  in  [NUM_CORES]  responder holds line (qualified by snoop_valid)
snoop_dirty  in  [NUM_CORES]  responder holds line dirty (M/O)
done_valid  out  1  one-cycle completion pulse
done_core_id  out  ID_W  requester of completed transaction
done_shared  out  1  OR of shared over counted responders
done_dirty  out  1  OR of dirty over counted responders
done_timeout  out  1  completion forced by timeout

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, rr_ptr=0, all registered outputs 0, timeout counter 0, collection mask cleared. core_req_ready=0 while rst=1. Reset mid-transaction aborts it: no done pulse, no ready.
- FSM: IDLE -> BROADCAST -> COLLECT -> DONE -> IDLE.
- IDLE:
  - If |core_req_valid, pick the first valid core scanning rr_ptr, rr_ptr+1, ... mod NUM_CORES.
  - core_req_ready[g]=1 combinationally in that cycle only; handshake completes there.
  - Latch addr/type/id into bus_* registers and go to BROADCAST.
  - Otherwise stay in IDLE. ready is 0 in all other states.
- Requester protocol: a core holds valid/addr/type stable until ready. Dropping valid before ready is legal and has no effect.
- BROADCAST: bus_valid=1 for exactly this one cycle. Load expect mask = all cores except bus_src_id, clear got mask, shared/dirty accumulators and counter. Go to COLLECT.
- COLLECT:
  - Each cycle: got |= snoop_valid & expect; shared_acc |= snoop_valid & snoop_shared & expect (dirty likewise).
  - Requester's own snoop_valid is ignored, as are duplicate strobes from an already-counted core.
  - Snoop inputs are ignored outside COLLECT.
  - Completion test uses the updated got, so same-cycle arrivals count.
  - If (got_next == expect): go to DONE, timeout_flag=0.
  - Else if counter == SNOOP_TIMEOUT-1: go to DONE, timeout_flag=1 (accumulators keep only the responses received).
  - Else counter++.
  - NUM_CORES=1: expect is empty, so exit to DONE after one COLLECT cycle.
- DONE:
  - done_valid=1 for one cycle, with done_core_id=bus_src_id, done_shared, done_dirty, done_timeout.
  - Set rr_ptr = (bus_src_id==NUM_CORES-1) ? 0 : bus_src_id+1. Go to IDLE.
- Outside DONE, done_* are held at 0. bus_addr/bus_type/bus_src_id hold their last value until the next accept.
- Latency: accept at cycle T, bus_valid at T+1, earliest done_valid at T+3. Maximum is T+2+SNOOP_TIMEOUT. Minimum spacing between accepts is 4 cycles.
- Assertions: core_req_ready is onehot0; bus_valid implies state==BROADCAST; done_valid is never asserted on two consecutive cycles.

Test Plan:
- Reset, then core 2 requests addr 0x1000 type 1; cores 0,1,3 return snoop_valid one cycle after bus_valid with shared only on core 1 -> ready[2] at T; bus_valid at T+1 with addr 0x1000, src 2; done at T+3 with id 2, shared 1, dirty 0, timeout 0.
- All 4 cores request continuously, all snoops respond immediately -> grants in order 0,1,2,3,0; every accept exactly 4 cycles apart.
- Core 0 requests; core 3 never responds; SNOOP_TIMEOUT=16 -> done_timeout=1 at T+18, with shared/dirty from cores 1,2 only.
- Requester core 1 asserts its own snoop_valid and dirty; core 2 strobes twice; core 3 responds dirty -> own response ignored, no double count, done_dirty=1 from core 3 only.
- Assert rst in the COLLECT cycle -> no done_valid, all outputs 0 on the next cycle, and the next grant starts from core 0.
- NUM_CORES=1 build: the single core requests -> bus_valid at T+1, done at T+3 with shared=0, dirty=0, timeout=0.
